rf_multiport: RTL and testbench
===============================

Name: rf_multiport

Overview:
- Parametrised successor to the single-write, three-read CPU register file.
- Configurable data width, register count and read-port count; two write ports with fixed priority.
- Register contents initialise through a hardware clear sequencer, not a reset of the whole array; a busy flag holds off the pipeline until the sweep finishes.
- Sits in the decode stage; writeback drives the write ports.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; the file holds 2**ADDR_W entries, entry 0 hard-wired to zero.
- NUM_RD, 3, number of combinational read ports (debug port counts as one).
- SP_IDX, 29, index loaded with SP_INIT by every clear sweep.
- SP_INIT, 32'h400, clear value for SP_IDX; every other entry clears to 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  global enable; gates both write ports only.
- clr_req  in  1  one-cycle pulse requesting a full clear sweep.
- busy  out  1  high while reset is asserted or a sweep is in progress.
- w0_en  in  1  write port 0 enable.
- w0_addr  in  ADDR_W  write port 0 address.
- w0_data  in  DATA_W  write port 0 data.
- w1_en  in  1  write port 1 enable.
- w1_addr  in  ADDR_W  write port 1 address.
- w1_data  in  DATA_W  write port 1 data.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing.

Behaviour:
- Sequencer states: RST, CLEAR, IDLE.
  - rst_n low: asynchronously enter RST, clr_idx=1, busy=1.
  - RST -> CLEAR on the first rising edge after rst_n deasserts.
- CLEAR:
  - Each cycle, write entry clr_idx with SP_INIT if clr_idx==SP_IDX, else 0; then increment clr_idx.
  - When clr_idx==2**ADDR_W-1 is written, clr_idx wraps to 1 and the state goes to IDLE.
  - Sweep length is exactly 2**ADDR_W-1 cycles (31 at default). busy is low from the first IDLE cycle.
- IDLE:
  - clr_req=1 -> CLEAR with clr_idx=1; busy rises the next cycle.
  - clr_req in RST or CLEAR is ignored; no restart, no queueing.
- Writes:
  - Performed only when state==IDLE, en=1, clr_req=0, wN_en=1 and wN_addr!=0.
  - Writes in any other case are silently dropped.
  - clr_req in IDLE wins over same-cycle writes.
  - Both ports enabled to the same address: port 1 wins; port 0 is discarded.
  - Address 0 writes are always discarded.
- Reads:
  - Combinational, zero latency.
  - rd_addr==0 returns 0.
  - While busy=1, every rd_data lane is forced to 0.
- Reset values: busy=1, all rd_data=0. Array entries are undefined until the first sweep completes; they are never observable because of the forced-0 reads.
- Reset mid-sweep: asynchronously abort, restart from RST; clr_idx returns to 1.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding. For each read lane with nonzero address, if port 1 performs a qualifying write to that address, return w1_data; else if port 0 does, return w0_data; else return the array value.
  - Qualifying means the write would actually occur, so forwarding is off while busy, en=0 or clr_req=1.
- Undefined: reads return the pre-edge array value; the written data is visible from the next cycle.

Decomposition:
- Package rf_pkg: state enum (RST, CLEAR, IDLE) and default constants for DATA_W, ADDR_W, NUM_RD, SP_IDX, SP_INIT.
- Sub-module rf_clear_seq:
  - Holds the FSM and clr_idx counter.
  - Outputs busy, clr_we, clr_addr, clr_data.
- Top level holds the array, write arbitration, read muxes and bypass.

Test Plan:
- Reset release: hold rst_n low 3 cycles, release -> busy=1 for exactly 31 cycles, then 0; read of addr 29 = 32'h400, addr 5 = 0.
- Writes: w0 to addr 3 with 32'hDEADBEEF in IDLE, en=1 -> read port 0 addr 3 returns 32'hDEADBEEF next cycle. Write to addr 0 -> reads 0.
- Write collision: w0 addr 7 = 1 and w1 addr 7 = 2 in the same cycle -> addr 7 reads 2. Repeat with en=0 -> addr 7 unchanged.
- Clear request: fill addr 4 = 32'h55; pulse clr_req together with w0 addr 4 = 32'h66 -> write dropped, busy for 31 cycles, then addr 4 = 0 and addr 29 = 32'h400. clr_req pulsed mid-sweep -> sweep length is still 31.
- Reset mid-sweep: assert rst_n low at sweep cycle 10 -> busy stays 1, rd_data=0. Release -> full 31-cycle sweep restarts.
- Bypass:
  - With RF_BYPASS_EN, write addr 9 = 32'hA5A5A5A5 while read lane 2 addresses 9 -> same-cycle rd_data lane 2 = 32'hA5A5A5A5.
  - Without the macro, the same-cycle read returns the old value.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and default geometry for the multiport register file.
package rf_pkg;

    localparam int          RF_DATA_W  = 32;
    localparam int          RF_ADDR_W  = 5;
    localparam int          RF_NUM_RD  = 3;
    localparam int          RF_SP_IDX  = 29;
    localparam logic [31:0] RF_SP_INIT = 32'h0000_0400;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_IDLE  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: sweeps entries 1..2**ADDR_W-1 after reset or on request,
// holding busy high until the sweep is complete.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int                DATA_W  = RF_DATA_W,
    parameter int                ADDR_W  = RF_ADDR_W,
    parameter int                SP_IDX  = RF_SP_IDX,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(RF_SP_INIT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data
);

    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] SP_ADDR   = ADDR_W'(SP_IDX);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] w_clr_idx_nxt;
    logic              r_busy;

    // State, sweep index and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_RST;
            r_clr_idx <= IDX_FIRST;
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    // Next-state logic and clear-port drive; requests outside IDLE are ignored.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        clr_we        = 1'b0;
        clr_addr      = r_clr_idx;
        clr_data      = {DATA_W{1'b0}};
        case (r_state)
            ST_RST: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_idx_nxt = IDX_FIRST;
            end
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (r_clr_idx == SP_ADDR) begin
                    clr_data = SP_INIT;
                end else begin
                    clr_data = {DATA_W{1'b0}};
                end
                if (r_clr_idx == IDX_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_idx_nxt = IDX_FIRST;
                end else begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_clr_idx_nxt = IDX_FIRST;
                end else begin
                    w_state_nxt   = ST_IDLE;
                    w_clr_idx_nxt = r_clr_idx;
                end
            end
            default: begin
                w_state_nxt   = ST_RST;
                w_clr_idx_nxt = IDX_FIRST;
            end
        endcase
    end

    assign busy = r_busy;

endmodule

// File: rtl/rf_multiport.sv
// Multiport register file: two prioritised write ports, NUM_RD combinational
// read ports, hardware clear sweep. Define RF_BYPASS_EN for write-to-read forwarding.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int                DATA_W  = RF_DATA_W,
    parameter int                ADDR_W  = RF_ADDR_W,
    parameter int                NUM_RD  = RF_NUM_RD,
    parameter int                SP_IDX  = RF_SP_IDX,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(RF_SP_INIT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clr_req,
    output logic                     busy,
    input  logic                     w0_en,
    input  logic [ADDR_W-1:0]        w0_addr,
    input  logic [DATA_W-1:0]        w0_data,
    input  logic                     w1_en,
    input  logic [ADDR_W-1:0]        w1_addr,
    input  logic [DATA_W-1:0]        w1_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data
);

    localparam int                NUM_ENT   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] r_mem [NUM_ENT];

    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_clr_data;
    logic              w_wr_gate;
    logic              w_wr0_ok;
    logic              w_wr1_ok;

    rf_clear_seq #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SP_IDX  (SP_IDX),
        .SP_INIT (SP_INIT)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr),
        .clr_data (w_clr_data)
    );

    // A clear request in IDLE wins over same-cycle writes; port 1 beats port 0.
    assign w_wr_gate = ~busy & en & ~clr_req;
    assign w_wr1_ok  = w_wr_gate & w1_en & (w1_addr != ADDR_ZERO);
    assign w_wr0_ok  = w_wr_gate & w0_en & (w0_addr != ADDR_ZERO)
                     & ~(w_wr1_ok & (w1_addr == w0_addr));

    // Storage array; entry 0 is never written and never read.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= w_clr_data;
        end else begin
            if (w_wr0_ok) begin
                r_mem[w0_addr] <= w0_data;
            end
            if (w_wr1_ok) begin
                r_mem[w1_addr] <= w1_data;
            end
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_lane_addr;
        logic [DATA_W-1:0] w_lane_data;

        assign w_lane_addr = rd_addr[g*ADDR_W +: ADDR_W];

        // Read mux: zero while busy or for address 0, optional forwarding.
        always_comb begin
            if (busy || (w_lane_addr == ADDR_ZERO)) begin
                w_lane_data = {DATA_W{1'b0}};
`ifdef RF_BYPASS_EN
            end else if (w_wr1_ok && (w1_addr == w_lane_addr)) begin
                w_lane_data = w1_data;
            end else if (w_wr0_ok && (w0_addr == w_lane_addr)) begin
                w_lane_data = w0_data;
`endif
            end else begin
                w_lane_data = r_mem[w_lane_addr];
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = w_lane_data;
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Randomised and directed bench for rf_multiport against a behavioural model.
module tb_rf_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;
    localparam int NE = 32;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b1;
    logic             en      = 1'b0;
    logic             clr_req = 1'b0;
    logic             w0_en   = 1'b0;
    logic             w1_en   = 1'b0;
    logic [AW-1:0]    w0_addr = '0;
    logic [AW-1:0]    w1_addr = '0;
    logic [DW-1:0]    w0_data = '0;
    logic [DW-1:0]    w1_data = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic             busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_multiport dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr_req (clr_req),
        .busy    (busy),
        .w0_en   (w0_en),
        .w0_addr (w0_addr),
        .w0_data (w0_data),
        .w1_en   (w1_en),
        .w1_addr (w1_addr),
        .w1_data (w1_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Model: "in reset" flag, cycles of sweep still to run, and the whole array.
    bit            m_in_rst = 1'b1;
    int            m_left   = 0;
    logic [DW-1:0] m_mem [NE];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_in_rst = 1'b1;
            m_left   = 0;
        end else if (m_in_rst) begin
            m_in_rst = 1'b0;
            m_left   = NE - 1;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                for (int i = 0; i < NE; i++) m_mem[i] = (i == 29) ? 32'h400 : 32'h0;
            end
        end else if (clr_req) begin
            m_left = NE - 1;
        end else if (en) begin
            if (w0_en && w0_addr != 0) m_mem[w0_addr] = w0_data;
            if (w1_en && w1_addr != 0) m_mem[w1_addr] = w1_data;
        end
    end

    function automatic bit m_busy();
        return m_in_rst || (m_left > 0);
    endfunction

    function automatic logic [DW-1:0] exp_lane(int k);
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        if (m_busy() || a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (en && !clr_req) begin
            if (w1_en && w1_addr == a) return w1_data;
            if (w0_en && w0_addr == a) return w0_data;
        end
`endif
        return m_mem[a];
    endfunction

    function automatic logic [DW-1:0] lane(int k);
        return rd_data[k*DW +: DW];
    endfunction

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        n_cmp++;
        if (busy !== m_busy()) begin
            n_fail++;
            $display("FAIL busy @%0t: got %b want %b", $time, busy, m_busy());
        end
        for (int k = 0; k < NR; k++) begin
            n_cmp++;
            if (lane(k) !== exp_lane(k)) begin
                n_fail++;
                $display("FAIL rd_lane%0d @%0t addr %0d: got %h want %h",
                         k, $time, rd_addr[k*AW +: AW], lane(k), exp_lane(k));
            end
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2);
        rd_addr[0*AW +: AW] = AW'(a0);
        rd_addr[1*AW +: AW] = AW'(a1);
        rd_addr[2*AW +: AW] = AW'(a2);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles from now; optionally pulses clr_req at sweep cycle pulse_at.
    task automatic count_busy(input int pulse_at, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            clr_req = (cnt == pulse_at);
            cnt++;
            step();
        end
        clr_req = 1'b0;
    endtask

    initial begin
        int c;
        #1 rst_n = 1'b0;
        set_rd(29, 5, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_rd0", lane(0), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        count_busy(-1, c);
        chk("reset_sweep_len", c, 32'd31);
        #1;
        chk("sp_init_addr29", lane(0), 32'h400);
        chk("cleared_addr5", lane(1), 32'h0);

        // Simple write then read on port 0.
        set_rd(3, 0, 29);
        en = 1'b1; w0_en = 1'b1; w0_addr = 5'd3; w0_data = 32'hDEADBEEF;
        step();
        w0_en = 1'b0;
        #1;
        chk("write_addr3", lane(0), 32'hDEADBEEF);

        // Address 0 write is discarded.
        w0_en = 1'b1; w0_addr = 5'd0; w0_data = 32'h12345678;
        step();
        w0_en = 1'b0;
        #1;
        chk("write_addr0", lane(1), 32'h0);

        // Collision: port 1 wins; then en=0 blocks both.
        set_rd(7, 3, 0);
        w0_en = 1'b1; w0_addr = 5'd7; w0_data = 32'd1;
        w1_en = 1'b1; w1_addr = 5'd7; w1_data = 32'd2;
        step();
        w0_en = 1'b0; w1_en = 1'b0;
        #1;
        chk("collision_w1_wins", lane(0), 32'd2);
        en = 1'b0;
        w0_en = 1'b1; w0_data = 32'd5; w1_en = 1'b1; w1_data = 32'd6;
        step();
        w0_en = 1'b0; w1_en = 1'b0; en = 1'b1;
        #1;
        chk("en0_no_write", lane(0), 32'd2);

        // Clear request beats a same-cycle write.
        set_rd(4, 29, 7);
        w0_en = 1'b1; w0_addr = 5'd4; w0_data = 32'h55;
        step();
        #1;
        chk("fill_addr4", lane(0), 32'h55);
        clr_req = 1'b1; w0_data = 32'h66;
        step();
        clr_req = 1'b0; w0_en = 1'b0;
        count_busy(-1, c);
        chk("clr_sweep_len", c, 32'd31);
        #1;
        chk("clr_addr4", lane(0), 32'h0);
        chk("clr_addr29", lane(1), 32'h400);
        chk("clr_addr7", lane(2), 32'h0);

        // clr_req during a sweep is ignored.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        count_busy(10, c);
        chk("midsweep_req_len", c, 32'd31);

        // Reset in the middle of a sweep restarts it.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_rd1", lane(1), 32'h0);
        repeat (2) step();
        chk("midrst_busy_hold", {31'd0, busy}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        count_busy(-1, c);
        chk("midrst_sweep_len", c, 32'd31);

        // Same-cycle read of a location being written.
        set_rd(0, 0, 9);
        w0_en = 1'b1; w0_addr = 5'd9; w0_data = 32'hA5A5A5A5;
        #1;
`ifdef RF_BYPASS_EN
        chk("bypass_same_cycle", lane(2), 32'hA5A5A5A5);
`else
        chk("no_bypass_same_cycle", lane(2), 32'h0);
`endif
        step();
        w0_en = 1'b0;
        #1;
        chk("bypass_next_cycle", lane(2), 32'hA5A5A5A5);

        // Random traffic checked every cycle by the compare process.
        for (int n = 0; n < 600; n++) begin
            en      = ($urandom_range(0, 9) != 0);
            clr_req = ($urandom_range(0, 59) == 0);
            w0_en   = $urandom_range(0, 1);
            w1_en   = $urandom_range(0, 1);
            w0_addr = AW'($urandom_range(0, NE - 1));
            w1_addr = ($urandom_range(0, 3) == 0) ? w0_addr : AW'($urandom_range(0, NE - 1));
            w0_data = $urandom;
            w1_data = $urandom;
            for (int k = 0; k < NR; k++) begin
                case ($urandom_range(0, 2))
                    0:       rd_addr[k*AW +: AW] = w0_addr;
                    1:       rd_addr[k*AW +: AW] = w1_addr;
                    default: rd_addr[k*AW +: AW] = AW'($urandom_range(0, NE - 1));
                endcase
            end
            step();
        end
        en = 1'b0; clr_req = 1'b0; w0_en = 1'b0; w1_en = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
